// File: rtl/io_periph_pkg.sv
// Shared constants for the memory-mapped input peripheral: register word
// offsets and the default debounce sample period.
package io_periph_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  localparam logic [2:0] OFF_SW     = 3'd0;
  localparam logic [2:0] OFF_BTN    = 3'd1;
  localparam logic [2:0] OFF_EDGE   = 3'd2;
  localparam logic [2:0] OFF_TIMER  = 3'd3;
  localparam logic [2:0] OFF_CMP    = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

endpackage

// File: rtl/io_input_periph_if.sv
// Load/store bus between the CPU's LSU (master) and the input peripheral (slave).
interface io_input_periph_if;

  logic        i_sel;
  logic        i_we;
  logic        i_re;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;

  modport master (output i_sel, i_we, i_re, i_addr, i_wdata, input o_rdata);
  modport slave  (input i_sel, i_we, i_re, i_addr, i_wdata, output o_rdata);

endinterface

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus tick-sampled debouncer; one shared prescaler
// serves every bit so all inputs are sampled on the same tick.
module io_debounce #(
  parameter int WIDTH  = 36,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] deb
);

  localparam int TW = (CYCLES <= 2) ? 1 : $clog2(CYCLES);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] samp_reg;
  logic [WIDTH-1:0] deb_reg;
  logic [TW-1:0]    tcnt_reg;
  logic             tick;

  assign tick = (tcnt_reg == TW'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      tcnt_reg <= '0;
    end else begin
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      tcnt_reg <= tick ? '0 : tcnt_reg + TW'(1);
    end
  end

  // A level is accepted only when two consecutive ticks agree on it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk) begin
      if (rst) begin
        samp_reg[gi] <= 1'b0;
        deb_reg[gi]  <= 1'b0;
      end else if (tick) begin
        samp_reg[gi] <= s2_reg[gi];
        if (s2_reg[gi] == samp_reg[gi])
          deb_reg[gi] <= s2_reg[gi];
      end
    end
  end

  assign deb = deb_reg;

endmodule

// File: rtl/io_input_periph.sv
// Input peripheral: debounced switches/buttons, sticky button-press flags,
// free-running cycle timer with compare-match flag, combinational read mux.
module io_input_periph
  import io_periph_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  io_input_periph_if.slave   bus,
  input  logic [31:0]        i_io_sw,
  input  logic [3:0]         i_io_btn,
  output logic               o_irq
);

  logic [35:0] deb_all;
  logic [31:0] deb_sw;
  logic [3:0]  deb_btn;
  logic [3:0]  btn_prev_reg;
  logic [3:0]  edge_reg, edge_next;
  logic [31:0] timer_reg, timer_next;
  logic [31:0] cmp_reg, cmp_next;
  logic        match_reg, match_next;
  logic        wr, rd;
  logic [2:0]  off;
  logic        unused_addr;

  io_debounce #(.WIDTH(36), .CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk (clk),
    .rst (rst),
    .raw ({i_io_btn, i_io_sw}),
    .deb (deb_all)
  );

  assign deb_sw      = deb_all[31:0];
  assign deb_btn     = deb_all[35:32];
  assign wr          = bus.i_sel & bus.i_we;
  assign rd          = bus.i_sel & bus.i_re;
  assign off         = bus.i_addr[4:2];
  assign unused_addr = ^{bus.i_addr[31:5], bus.i_addr[1:0]};

  always_comb begin
    edge_next  = edge_reg;
    timer_next = timer_reg + 32'd1;
    cmp_next   = cmp_reg;
    match_next = match_reg;
    if (wr && off == OFF_EDGE)   edge_next  = edge_reg & ~bus.i_wdata[3:0];
    if (wr && off == OFF_TIMER)  timer_next = bus.i_wdata;
    if (wr && off == OFF_CMP)    cmp_next   = bus.i_wdata;
    if (wr && off == OFF_STATUS && bus.i_wdata[0]) match_next = 1'b0;
    // Sets are applied after clears so a same-cycle event is never lost.
    edge_next = edge_next | (deb_btn & ~btn_prev_reg);
    if (timer_reg == cmp_reg) match_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_reg <= '0;
      edge_reg     <= '0;
      timer_reg    <= '0;
      cmp_reg      <= '0;
      match_reg    <= 1'b0;
    end else begin
      btn_prev_reg <= deb_btn;
      edge_reg     <= edge_next;
      timer_reg    <= timer_next;
      cmp_reg      <= cmp_next;
      match_reg    <= match_next;
    end
  end

  always_comb begin
    bus.o_rdata = '0;
    if (rd) begin
      case (off)
        OFF_SW:     bus.o_rdata = deb_sw;
        OFF_BTN:    bus.o_rdata = {28'd0, deb_btn};
        OFF_EDGE:   bus.o_rdata = {28'd0, edge_reg};
        OFF_TIMER:  bus.o_rdata = timer_reg;
        OFF_CMP:    bus.o_rdata = cmp_reg;
        OFF_STATUS: bus.o_rdata = {31'd0, match_reg};
        default:    bus.o_rdata = '0;
      endcase
    end
  end

  assign o_irq = (|edge_reg) | match_reg;

endmodule
